// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store initiator for a word-organised data memory
// with no byte enables. Sub-word stores are done as read-modify-write.
// Optional feature macro: LSU_MISALIGN_CHECK_EN (when defined, misaligned
// halfword/word requests fault instead of being forced aligned).
module load_store_unit #(
  parameter int unsigned N = 32,
  parameter int unsigned A = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [2:0]   req_funct3,
  input  logic [A-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_rdata,
  output logic         resp_misaligned,
  output logic         resp_illegal,
  output logic [A-1:0] mem_raddr,
  input  logic [N-1:0] mem_rdata,
  output logic [A-1:0] mem_waddr,
  output logic [N-1:0] mem_wdata,
  output logic         mem_we
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  state_t       state;
  logic [2:0]   f3_q;
  logic [1:0]   lane_q;
  logic [N-1:0] wdata_q;
  logic [A-1:0] word_idx;

  logic         req_illegal;
  logic         req_misaligned;
  logic         req_fault;
  logic [7:0]   byte_val;
  logic [15:0]  half_val;
  logic [4:0]   byte_sh;
  logic [4:0]   half_sh;
  logic [N-1:0] load_ext;
  logic [N-1:0] merged;

  // Both memory ports address the same word for the whole transaction.
  assign mem_raddr = word_idx;
  assign mem_waddr = word_idx;

  // Classify the incoming request (illegal funct3, misalignment).
  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    if (req_we) begin
      req_illegal = (req_funct3 > 3'd2);
    end else begin
      req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end
`ifdef LSU_MISALIGN_CHECK_EN
    if (!req_illegal) begin
      case (req_funct3[1:0])
        2'b01:   req_misaligned = req_addr[0];
        2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
        default: req_misaligned = 1'b0;
      endcase
    end
`endif
    req_fault = req_illegal | req_misaligned;
  end

  // Lane extraction/extension for loads and lane merge for sub-word stores.
  // Forced alignment falls out naturally: halves use lane_q[1] only, words no lane.
  always_comb begin
    byte_sh  = {lane_q, 3'b000};
    half_sh  = {lane_q[1], 4'b0000};
    byte_val = 8'(mem_rdata >> byte_sh);
    half_val = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_ext = {{(N-8){byte_val[7]}}, byte_val};
      3'b001:  load_ext = {{(N-16){half_val[15]}}, half_val};
      3'b100:  load_ext = {{(N-8){1'b0}}, byte_val};
      3'b101:  load_ext = {{(N-16){1'b0}}, half_val};
      default: load_ext = mem_rdata;
    endcase
    case (f3_q[1:0])
      2'b00:   merged = (mem_rdata & ~(N'(8'hFF) << byte_sh)) |
                        (N'(wdata_q[7:0]) << byte_sh);
      2'b01:   merged = (mem_rdata & ~(N'(16'hFFFF) << half_sh)) |
                        (N'(wdata_q[15:0]) << half_sh);
      default: merged = wdata_q;
    endcase
  end

  // Transaction FSM with registered request latch, memory and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      req_ready       <= 1'b0;
      f3_q            <= 3'b000;
      lane_q          <= 2'b00;
      wdata_q         <= '0;
      word_idx        <= '0;
      mem_we          <= 1'b0;
      mem_wdata       <= '0;
      resp_valid      <= 1'b0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
      resp_illegal    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            f3_q      <= req_funct3;
            lane_q    <= req_addr[1:0];
            wdata_q   <= req_wdata;
            word_idx  <= {2'b00, req_addr[A-1:2]};
            if (req_fault) begin
              state           <= RESP;
              resp_valid      <= 1'b1;
              resp_rdata      <= '0;
              resp_misaligned <= req_misaligned;
              resp_illegal    <= req_illegal;
            end else if (!req_we) begin
              state <= LOAD;
            end else if (req_funct3[1:0] == 2'b10) begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              state <= RMW_RD;
            end
          end
        end
        LOAD: begin
          state           <= RESP;
          resp_valid      <= 1'b1;
          resp_rdata      <= load_ext;
          resp_misaligned <= 1'b0;
          resp_illegal    <= 1'b0;
        end
        RMW_RD: begin
          state     <= WRITE;
          mem_we    <= 1'b1;
          mem_wdata <= merged;
        end
        WRITE: begin
          state           <= RESP;
          mem_we          <= 1'b0;
          resp_valid      <= 1'b1;
          resp_rdata      <= '0;
          resp_misaligned <= 1'b0;
          resp_illegal    <= 1'b0;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed requests against a small word
// memory, with a behavioural reference model and a per-cycle compare process.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_illegal;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_we;

  load_store_unit #(.N(32), .A(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  typedef struct {
    logic [31:0] rdata;
    bit          mis;
    bit          ill;
    bit          wr;
    int          widx;
    logic [31:0] wdata;
    int          edges;
  } exp_t;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        load_mem;
  exp_t        exp_q[$];
  exp_t        cmp_e;
  int          checks;
  int          errors;
  int          we_cycles;
  logic [31:0] last_waddr;
  logic [31:0] rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    if (i == 5) return 32'h8899AABB;
    return {8'(i), 8'hA5, 8'(i * 3), 8'h5A};
  endfunction

  // Data memory: asynchronous read, write on rising edge.
  assign mem_rdata = mem[mem_raddr[5:0]];
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (mem_we) begin
      mem[mem_waddr[5:0]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: what a request must produce, from the ISA rules on the model memory.
  function automatic exp_t model(bit we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd);
    exp_t        e;
    int          size;
    int          a;
    int          sh;
    logic [31:0] word;
    logic [31:0] val;
    logic [31:0] mask;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e.ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    a = int'(addr);
`ifdef LSU_MISALIGN_CHECK_EN
    e.mis = !e.ill && ((a % size) != 0);
`else
    e.mis = 1'b0;
    a = a - (a % size);
`endif
    e.widx  = a / 4;
    e.wr    = 1'b0;
    e.wdata = 32'h0;
    e.rdata = 32'h0;
    word    = ref_mem[e.widx];
    sh      = (a % 4) * 8;
    if (e.ill || e.mis) begin
      e.edges = 1;
    end else if (!we) begin
      val = word >> sh;
      if (size == 1) begin
        val = val & 32'hFF;
        if (!f3[2] && val[7]) val = val | 32'hFFFFFF00;
      end else if (size == 2) begin
        val = val & 32'hFFFF;
        if (!f3[2] && val[15]) val = val | 32'hFFFF0000;
      end
      e.rdata = val;
      e.edges = 2;
    end else begin
      mask    = (size == 4) ? 32'hFFFFFFFF : (((32'h1 << (8 * size)) - 32'h1) << sh);
      e.wdata = (word & ~mask) | ((wd << sh) & mask);
      e.wr    = 1'b1;
      e.edges = (size == 4) ? 2 : 3;
    end
    return e;
  endfunction

  // Per-cycle compare of memory traffic and responses against the model queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && !req_ready)
        chk("mem_raddr", mem_raddr, 32'(exp_q[0].widx));
      if (mem_we) begin
        we_cycles++;
        last_waddr = mem_waddr;
        if (exp_q.size() == 0 || !exp_q[0].wr) begin
          checks++;
          errors++;
          $display("FAIL unexpected_we actual=1 required=0 waddr=%h", mem_waddr);
        end else begin
          chk("mem_waddr", mem_waddr, 32'(exp_q[0].widx));
          chk("mem_wdata", mem_wdata, exp_q[0].wdata);
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual=1 required=0");
        end else begin
          cmp_e = exp_q.pop_front();
          chk("resp_rdata", resp_rdata, cmp_e.rdata);
          chk("resp_misaligned", 32'(resp_misaligned), 32'(cmp_e.mis));
          chk("resp_illegal", 32'(resp_illegal), 32'(cmp_e.ill));
        end
      end
    end
  end

  // Issue one request, check latency, busy ready, write count and memory result.
  task automatic run(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, output logic [31:0] rdata);
    exp_t e;
    int   n;
    int   k;
    e = model(we, f3, addr, wd);
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    chk("ready_before_accept", 32'(req_ready), 32'd1);
    we_cycles = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("busy_ready", 32'(req_ready), 32'd0);
    n = 1;
    while (!resp_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk("latency", 32'(n), 32'(e.edges));
    rdata = resp_rdata;
    if (!resp_valid) exp_q.delete();
    @(negedge clk);
    chk("we_cycles", 32'(we_cycles), e.wr ? 32'd1 : 32'd0);
    if (e.wr) ref_mem[e.widx] = e.wdata;
    chk("mem_word", mem[e.widx], ref_mem[e.widx]);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_resp_mis"}, 32'(resp_misaligned), 32'd0);
    chk({tag, "_resp_ill"}, 32'(resp_illegal), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    checks = 0; errors = 0; we_cycles = 0; last_waddr = 32'h0;
    rst = 1'b1; load_mem = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

    // Reset state.
    @(posedge clk); #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk_idle_outputs("rst");
    chk("rst_mem_raddr", mem_raddr, 32'd0);
    chk("rst_mem_waddr", mem_waddr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk); rst = 1'b0; load_mem = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Loads from word 5 = 0x8899AABB.
    run(1'b0, 3'b000, 32'h15, 32'h0, rd); chk("lb_15_lit", rd, 32'hFFFFFFAA);
    run(1'b0, 3'b100, 32'h15, 32'h0, rd); chk("lbu_15_lit", rd, 32'h000000AA);
    run(1'b0, 3'b001, 32'h16, 32'h0, rd); chk("lh_16_lit", rd, 32'hFFFF8899);
    run(1'b0, 3'b101, 32'h14, 32'h0, rd); chk("lhu_14_lit", rd, 32'h0000AABB);
    run(1'b0, 3'b000, 32'h17, 32'h0, rd); chk("lb_17_lit", rd, 32'hFFFFFF88);

    // Word store then load back.
    run(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, rd);
    chk("sw_waddr_lit", last_waddr, 32'd8);
    chk("sw_mem_lit", mem[8], 32'hDEADBEEF);
    run(1'b0, 3'b010, 32'h20, 32'h0, rd); chk("lw_20_lit", rd, 32'hDEADBEEF);

    // Sub-word read-modify-write stores; upper wdata bits must be ignored.
    run(1'b1, 3'b000, 32'h22, 32'hFFFFFF12, rd); chk("sb_mem_lit", mem[8], 32'hDE12BEEF);
    run(1'b1, 3'b001, 32'h20, 32'hABCD3456, rd); chk("sh_mem_lit", mem[8], 32'hDE123456);
    run(1'b0, 3'b100, 32'h22, 32'h0, rd); chk("lbu_22_lit", rd, 32'h00000012);
    run(1'b0, 3'b101, 32'h22, 32'h0, rd); chk("lhu_22_lit", rd, 32'h0000DE12);

    // Misaligned requests.
    run(1'b0, 3'b010, 32'h21, 32'h0, rd);
`ifdef LSU_MISALIGN_CHECK_EN
    chk("lw_21_mis_lit", 32'(resp_misaligned), 32'd1);
    chk("lw_21_rdata_lit", rd, 32'h0);
`else
    chk("lw_21_lit", rd, 32'hDE123456);
`endif
    run(1'b0, 3'b001, 32'h23, 32'h0, rd);
    run(1'b1, 3'b001, 32'h25, 32'h00007777, rd);
    run(1'b1, 3'b010, 32'h27, 32'h11223344, rd);

    // Illegal funct3.
    run(1'b0, 3'b011, 32'h20, 32'h0, rd);
    chk("ld011_ill_lit", 32'(resp_illegal), 32'd1);
    chk("ld011_rdata_lit", rd, 32'h0);
    run(1'b0, 3'b110, 32'h20, 32'h0, rd);
    run(1'b0, 3'b111, 32'h20, 32'h0, rd);
    run(1'b1, 3'b100, 32'h20, 32'h000000FF, rd);
    chk("sb100_ill_lit", 32'(resp_illegal), 32'd1);
    chk("sb100_mem_lit", mem[8], 32'hDE123456);

    // Reset asserted while an SH is in its write cycle.
    e = model(1'b1, 3'b001, 32'h22, 32'h00009999);
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h22; req_wdata = 32'h9999;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rmw_write_we", 32'(mem_we), 32'd1);
    @(negedge clk); #1;
    rst = 1'b1; #1;
    chk("rst_drops_we", 32'(mem_we), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    chk("rst_mid_ready", 32'(req_ready), 32'd0);
    chk_idle_outputs("rst_mid");
    chk("rst_mem_unchanged", mem[8], 32'hDE123456);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rel_ready", 32'(req_ready), 32'd1);
    chk_idle_outputs("rel");

    // Normal operation after reset.
    run(1'b0, 3'b010, 32'h20, 32'h0, rd); chk("lw_after_rst_lit", rd, 32'hDE123456);
    run(1'b0, 3'b000, 32'h14, 32'h0, rd); chk("lb_14_lit", rd, 32'hFFFFFFBB);

    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side initiator for the word-organised data memory: accepts RV32 load/store requests from the execute stage, converts byte addresses to word indices, drives the memory's read/write ports, and returns extracted, sign- or zero-extended load data. Byte and halfword stores are performed as read-modify-write because the memory has no byte enables. It sits between the execute stage and `data_memory`. It owns every memory access and reports misaligned or illegal requests without touching memory.

## Interface
- `N`, 32, data width; only 32 is supported because byte-lane logic assumes four lanes.
- `A`, 32, address width of the core request and of both memory address ports.

- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block idle and able to accept.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32 funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
- `req_addr` in A: byte address.
- `req_wdata` in N: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out N: extended load data; 0 for stores and faults.
- `resp_misaligned` out 1: request faulted on alignment; valid with `resp_valid`.
- `resp_illegal` out 1: funct3 is illegal for the direction; valid with `resp_valid`.
- `mem_raddr` out A: word index to memory. The memory has an asynchronous read.
- `mem_rdata` in N: memory read data.
- `mem_waddr` out A: word index for the write.
- `mem_wdata` out N: word to write.
- `mem_we` out 1: write enable; the memory writes on the rising edge of `clk`.

## Operation
- Word index = `{2'b00, addr[A-1:2]}`, registered at accept. Both `mem_raddr` and `mem_waddr` carry it until the next accept.
- Accept happens when `req_valid && req_ready`. At accept, `req_we`, `req_funct3`, `req_addr` and `req_wdata` are latched. `req_ready` is high only in IDLE.
- FSM states and transitions:
  - IDLE: on accept, go to RESP if the request faults (illegal or misaligned); to LOAD for a load; to WRITE for SW; to RMW_RD for SB or SH.
  - LOAD: sample `mem_rdata`, extract and extend into `resp_rdata`, then go to RESP.
  - RMW_RD: sample `mem_rdata` into the merge register, then go to WRITE.
  - WRITE: `mem_we`=1 for exactly this cycle, `mem_wdata` = merged word, then go to RESP.
  - RESP: `resp_valid`=1 for one cycle, then go to IDLE. There is no response backpressure.
- Illegal requests: load funct3 of 011, 110 or 111, and any store funct3 other than 000, 001 or 010.
- Misaligned requests: halfword with `addr[0]`=1, or word with `addr[1:0]`≠00. See Configuration.
- Load extraction:
  - Byte lane is `addr[1:0]`, so lane k is bits [8k+7:8k].
  - Half lane is `addr[1]`.
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- Store merge:
  - SB replaces lane `addr[1:0]` with `wdata[7:0]`.
  - SH replaces half `addr[1]` with `wdata[15:0]`.
  - SW writes `wdata` whole.
  - All other bits come from the word read in RMW_RD.
- A faulted request never asserts `mem_we`. `resp_rdata` is 0 for it.
- Reset while `rst` is high:
  - State is IDLE, `req_ready`=0.
  - These outputs are 0: `resp_valid`, `resp_rdata`, `resp_misaligned`, `resp_illegal`, `mem_we`, `mem_raddr`, `mem_waddr`, `mem_wdata`.
  - Reset in WRITE drops `mem_we` immediately; the pending write is lost.
  - Reset mid-RMW leaves memory unmodified.

## Timing
- The accept edge is E0.
- Load: `resp_valid` is high in the cycle after E1, so the load takes 2 edges.
- SW: `mem_we` is high in the cycle E0→E1; `resp_valid` is high after E1.
- SB/SH:
  - The read occurs in the cycle E0→E1.
  - `mem_we` is high in the cycle E1→E2.
  - `resp_valid` is high after E2, so the store takes 3 edges.
- Fault: `resp_valid` is high in the cycle after E0, with no memory activity.
- Throughput: the next accept can occur in the cycle following RESP. `req_ready` is low from E0 until RESP ends.
- `resp_*` outputs are registered and hold their values until the next response. `mem_*` outputs are registered or decoded from state, with no combinational path from `req_*`.

## Configuration
- `LSU_MISALIGN_CHECK_EN`:
  - When defined, misaligned halfword/word requests fault as described in Operation.
  - When undefined, misaligned requests are forced aligned before use: LH, LHU and SH ignore `addr[0]`; LW and SW ignore `addr[1:0]`. `resp_misaligned` is tied to 0.
  - Illegal-funct3 detection is unaffected.

## Test plan
- Memory word 5 = 0x8899AABB; LB at address 0x15 → `resp_rdata`=0xFFFFFFAA two edges after accept; LBU at the same address → 0x000000AA.
- SW 0xDEADBEEF at 0x20 → `mem_we` high exactly one cycle, `mem_waddr`=8; a following LW at 0x20 → 0xDEADBEEF.
- Word 8 = 0xDEADBEEF; SB 0x12 at 0x22 → word 8 becomes 0xDE12BEEF; SH 0x3456 at 0x20 → word 8 becomes 0xDE123456, each with `resp_valid` 3 edges after accept.
- With the macro defined, LW at 0x21 → `resp_valid` and `resp_misaligned` high one edge after accept, `mem_we` never high. Without the macro, the same LW returns word 8.
- Load with funct3=011 → `resp_illegal`=1, `resp_rdata`=0; SB with funct3=100 → `resp_illegal`=1, no write.
- Assert `rst` while in WRITE of an SH → `mem_we` falls immediately, memory is unchanged, and after release `req_ready`=1 with all response outputs at 0.
